// File: rtl/hack_control_unit.sv
// hack_control_unit: multi-cycle sequencer for the Hack datapath.
// Fetches from the shared single-port RAM, decodes, and drives every
// load/select/strobe for the A/D registers, ALU, RAM and PC.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start                 : one-cycle pulse, accepted only in IDLE
//   mem_rdata             : RAM read data (1-cycle read latency)
//   pc_q, a_q             : current PC and low bits of A (halt compare)
//   alu_zr, alu_ng        : ALU flags, used in EXEC for jump resolution
//   ir, alu_ctrl          : instruction register and its comp field
//   alu_y_sel ... pc_target_sel : datapath strobes (gated by reset)
//   busy, halted          : status; retired : completed-instruction count
module hack_control_unit #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned BOOT_ADDR = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       mem_rdata,
  input  logic [ADDR_W-1:0] pc_q,
  input  logic [ADDR_W-1:0] a_q,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [15:0]       ir,
  output logic [5:0]        alu_ctrl,
  output logic              alu_y_sel,
  output logic              mem_addr_sel,
  output logic              mem_we,
  output logic              a_load,
  output logic              a_sel,
  output logic              d_load,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              pc_target_sel,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retired
);

  // The boot address is muxed in by the PC itself; it must fit the address space.
  if ((BOOT_ADDR >> ADDR_W) != 0) begin : g_boot_addr_check
    $error("hack_control_unit: BOOT_ADDR does not fit in ADDR_W bits");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BOOT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_LATCH = 3'd3,
    ST_MREAD = 3'd4,
    ST_EXEC  = 3'd5,
    ST_HALT  = 3'd6
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   prev_a_q;    // last retired instruction was an A-instruction

  logic ir_is_c;
  logic fetched_needs_m;
  logic jump_c;
  logic halt_c;

  assign ir_is_c  = ir[15];
  assign alu_ctrl = ir[11:6];

  // Decided on the incoming word because ir is only being loaded at this edge.
  assign fetched_needs_m = mem_rdata[15] & mem_rdata[12];

  assign jump_c = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_zr & ~alu_ng);

  // "@here-1; 0;JMP" idiom: unconditional jump back onto the preceding A-instruction.
  assign halt_c = ir_is_c & (ir[2:0] == 3'b111) & prev_a_q
                & (a_q == pc_q - ADDR_W'(1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_BOOT;
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: state_d = fetched_needs_m ? ST_MREAD : ST_EXEC;
      ST_MREAD: state_d = ST_EXEC;
      ST_EXEC:  state_d = halt_c ? ST_HALT : ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs; strobes are forced low while reset is asserted.
  always_comb begin
    alu_y_sel     = 1'b0;
    mem_addr_sel  = 1'b0;
    mem_we        = 1'b0;
    a_load        = 1'b0;
    a_sel         = 1'b0;
    d_load        = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    pc_target_sel = 1'b0;
    busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
    halted        = (state_q == ST_HALT);
    case (state_q)
      ST_BOOT: begin
        pc_load       = 1'b1;
        pc_target_sel = 1'b1;
      end
      ST_MREAD: mem_addr_sel = 1'b1;
      ST_EXEC: begin
        if (!ir_is_c) begin
          a_load = 1'b1;
          pc_inc = 1'b1;
        end else begin
          alu_y_sel    = ir[12];
          mem_addr_sel = 1'b1;
          a_load       = ir[5];
          a_sel        = 1'b1;
          d_load       = ir[4];
          mem_we       = ir[3];
          pc_load      = jump_c;
          pc_inc       = ~jump_c;
        end
      end
      default: ;
    endcase
    if (reset) begin
      alu_y_sel     = 1'b0;
      mem_addr_sel  = 1'b0;
      mem_we        = 1'b0;
      a_load        = 1'b0;
      a_sel         = 1'b0;
      d_load        = 1'b0;
      pc_inc        = 1'b0;
      pc_load       = 1'b0;
      pc_target_sel = 1'b0;
    end
  end

  // IR capture, retire counter and the A-instruction history flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir       <= 16'd0;
      retired  <= 16'd0;
      prev_a_q <= 1'b0;
    end else begin
      if (state_q == ST_LATCH) ir <= mem_rdata;
      if (state_q == ST_EXEC) begin
        retired  <= retired + 16'd1;
        prev_a_q <= ~ir[15];
      end
    end
  end

endmodule

// File: tb/tb_hack_control_unit.sv
// Testbench for hack_control_unit: directed program steps followed by a
// randomized instruction stream, compared cycle by cycle against an
// instruction-level model of the expected strobe sequence.
module tb_hack_control_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] mem_rdata;
  logic [6:0]  pc_q;
  logic [6:0]  a_q;
  logic        alu_zr;
  logic        alu_ng;
  logic [15:0] ir;
  logic [5:0]  alu_ctrl;
  logic        alu_y_sel, mem_addr_sel, mem_we, a_load, a_sel, d_load;
  logic        pc_inc, pc_load, pc_target_sel, busy, halted;
  logic [15:0] retired;

  hack_control_unit #(.ADDR_W(7), .BOOT_ADDR(64)) dut (
    .clock(clock), .reset(reset), .start(start), .mem_rdata(mem_rdata),
    .pc_q(pc_q), .a_q(a_q), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .ir(ir), .alu_ctrl(alu_ctrl), .alu_y_sel(alu_y_sel),
    .mem_addr_sel(mem_addr_sel), .mem_we(mem_we), .a_load(a_load),
    .a_sel(a_sel), .d_load(d_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_target_sel(pc_target_sel), .busy(busy), .halted(halted),
    .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] ir;
    logic [5:0]  alu_ctrl;
    logic        alu_y_sel;
    logic        mem_addr_sel;
    logic        mem_we;
    logic        a_load;
    logic        a_sel;
    logic        d_load;
    logic        pc_inc;
    logic        pc_load;
    logic        pc_target_sel;
    logic        busy;
    logic        halted;
    logic [15:0] retired;
  } obs_t;

  obs_t obs;
  assign obs = {ir, alu_ctrl, alu_y_sel, mem_addr_sel, mem_we, a_load, a_sel,
                d_load, pc_inc, pc_load, pc_target_sel, busy, halted, retired};

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction-level model state.
  logic [15:0] m_ir;
  int          m_ret;
  bit          m_prev_a;

  function automatic obs_t base_exp(input logic bsy, input logic hlt);
    obs_t e;
    e          = '0;
    e.ir       = m_ir;
    e.alu_ctrl = m_ir[11:6];
    e.busy     = bsy;
    e.halted   = hlt;
    e.retired  = 16'(m_ret % 65536);
    return e;
  endfunction

  task automatic check(input string tag, input obs_t e);
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset, then start pulse; leaves the bench in the first FETCH cycle.
  task automatic boot_seq();
    obs_t e;
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    m_ir = 16'h0000; m_ret = 0; m_prev_a = 0;
    #1 check("reset_idle", base_exp(1'b0, 1'b0));
    reset = 1'b0;
    #1 check("idle", base_exp(1'b0, 1'b0));
    start = 1'b1;
    #1 check("idle_start", base_exp(1'b0, 1'b0));
    tick();
    start = 1'b0;
    e = base_exp(1'b1, 1'b0);
    e.pc_load = 1'b1;
    e.pc_target_sel = 1'b1;
    #1 check("boot", e);
    tick();
  endtask

  // One instruction from FETCH through EXEC (and HALT if it halts).
  task automatic do_instr(input logic [15:0] w, input logic [6:0] aq,
                          input logic [6:0] pcq, input logic zr, input logic ng,
                          input bit rst_exec, output bit hit_halt);
    obs_t e;
    bit   is_c, take, halt;
    hit_halt = 0;
    is_c = w[15];
    mem_rdata = w; a_q = aq; pc_q = pcq; alu_zr = zr; alu_ng = ng;
    e = base_exp(1'b1, 1'b0);
    #1 check("fetch", e);
    tick();
    #1 check("latch", e);
    tick();
    m_ir = w;
    if (is_c && w[12]) begin
      e = base_exp(1'b1, 1'b0);
      e.mem_addr_sel = 1'b1;
      #1 check("mread", e);
      tick();
    end
    // Expected EXEC effects, straight from the instruction fields.
    e = base_exp(1'b1, 1'b0);
    if (!is_c) begin
      e.a_load = 1'b1;
      e.pc_inc = 1'b1;
    end else begin
      take = (w[2] && ng) || (w[1] && zr) || (w[0] && !zr && !ng);
      e.alu_y_sel    = w[12];
      e.mem_addr_sel = 1'b1;
      e.a_load       = w[5];
      e.a_sel        = 1'b1;
      e.d_load       = w[4];
      e.mem_we       = w[3];
      e.pc_load      = take;
      e.pc_inc       = !take;
    end
    if (rst_exec) begin
      reset = 1'b1;
      e = base_exp(1'b1, 1'b0);
      #1 check("exec_in_reset", e);
      tick();
      m_ir = 16'h0000; m_ret = 0; m_prev_a = 0;
      reset = 1'b0;
      #1 check("after_exec_reset", base_exp(1'b0, 1'b0));
      return;
    end
    #1 check(is_c ? "exec_c" : "exec_a", e);
    halt = is_c && (w[2:0] == 3'b111) && m_prev_a &&
           (int'(aq) == (int'(pcq) + 127) % 128);
    m_ret++;
    m_prev_a = !is_c;
    tick();
    if (halt) begin
      hit_halt = 1;
      #1 check("halt", base_exp(1'b0, 1'b1));
    end
  endtask

  initial begin
    bit          h;
    logic [15:0] w;
    logic [6:0]  pcq, aq;
    reset = 1'b1; start = 1'b0; mem_rdata = '0; pc_q = '0; a_q = '0;
    alu_zr = 1'b0; alu_ng = 1'b0;
    m_ir = 16'h0000; m_ret = 0; m_prev_a = 0;

    // Boot, then a short directed program.
    boot_seq();
    do_instr(16'h0005, 7'd3, 7'd64, 1'b0, 1'b0, 0, h);   // @5
    do_instr(16'hFDD0, 7'd5, 7'd65, 1'b0, 1'b1, 0, h);   // D=M+1
    do_instr(16'hEA82, 7'd5, 7'd66, 1'b1, 1'b0, 0, h);   // 0;JEQ taken
    do_instr(16'hEA82, 7'd5, 7'd67, 1'b0, 1'b0, 0, h);   // 0;JEQ not taken

    // Halt idiom; start afterwards must be ignored.
    do_instr(16'h0046, 7'd5, 7'd70, 1'b1, 1'b0, 0, h);   // @70
    do_instr(16'hEA87, 7'd70, 7'd71, 1'b1, 1'b0, 0, h);  // 0;JMP
    n_cmp++;
    assert (h) else begin
      n_bad++;
      $error("FAIL halt_reached: observed=%0d expected=1", h);
    end
    for (int k = 0; k < 3; k++) begin
      start = (k == 0);
      tick();
      start = 1'b0;
      #1 check("halt_hold", base_exp(1'b0, 1'b1));
    end

    // Reset asserted during EXEC of M=D: no write, back to IDLE.
    boot_seq();
    do_instr(16'h0010, 7'd1, 7'd64, 1'b0, 1'b0, 0, h);
    do_instr(16'hE308, 7'd16, 7'd65, 1'b0, 1'b0, 1, h);

    // Halt compare wraps modulo 2^ADDR_W.
    boot_seq();
    do_instr(16'h007F, 7'd0, 7'd127, 1'b0, 1'b0, 0, h);
    do_instr(16'hEA87, 7'd127, 7'd0, 1'b0, 1'b1, 0, h);
    n_cmp++;
    assert (h) else begin
      n_bad++;
      $error("FAIL halt_wrap: observed=%0d expected=1", h);
    end

    // Randomized instruction stream; re-boot whenever the model predicts a halt.
    boot_seq();
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom);
      w[15] = ($urandom_range(0, 1) == 1);
      if (w[15] && $urandom_range(0, 3) == 0) w[2:0] = 3'b111;
      pcq = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) aq = 7'((int'(pcq) + 127) % 128);
      else aq = 7'($urandom_range(0, 127));
      do_instr(w, aq, pcq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, h);
      if (h) boot_seq();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hack_control_unit.md
# hack_control_unit

Multi-cycle sequencer for the Hack datapath. It fetches instructions from the single-port shared RAM, decodes them, and drives every load, select and strobe for the A/D registers, ALU, RAM and program counter. It sits between the external `pc`, `ram`, `alu` and A/D registers. It owns the IR, boot sequencing, jump resolution, halt detection and a retired-instruction counter.

## Interface
- `ADDR_W`, 7: RAM address width; also the width used for the halt compare.
- `BOOT_ADDR`, 64: first program word; loaded into the PC on start.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; accepted only in IDLE.
- `mem_rdata` in 16: RAM output, valid 1 cycle after the address is driven.
- `pc_q` in ADDR_W: current PC value.
- `a_q` in ADDR_W: current A register, low bits.
- `alu_zr` in 1: ALU zero flag.
- `alu_ng` in 1: ALU negative flag.
- `ir` out 16: instruction register.
- `alu_ctrl` out 6: {zx,nx,zy,ny,f,no} = `ir[11:6]`.
- `alu_y_sel` out 1: 0 = A, 1 = M (`mem_rdata`).
- `mem_addr_sel` out 1: 0 = PC, 1 = A.
- `mem_we` out 1: write ALU output to RAM[A].
- `a_load` out 1: load the A register.
- `a_sel` out 1: A source; 0 = IR, 1 = ALU output.
- `d_load` out 1: load the D register.
- `pc_inc` out 1: increment the PC.
- `pc_load` out 1: load the PC.
- `pc_target_sel` out 1: PC load source; 0 = A, 1 = `BOOT_ADDR`.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in the HALT state.
- `retired` out 16: count of completed instructions, wraps at 0xFFFF→0.

## Operation
- Encoding (standard Hack):
  - `ir[15]=0` is an A-instruction.
  - `ir[15]=1` is a C-instruction with fields: `ir[12]` a-bit, `ir[11:6]` comp, `ir[5:3]` dest {A,D,M}, `ir[2:0]` jump {lt,eq,gt}.
- States: IDLE, BOOT, FETCH, LATCH, MREAD, EXEC, HALT.
- IDLE:
  - All strobes are 0.
  - `start` → BOOT.
- BOOT:
  - `pc_load=1`, `pc_target_sel=1`.
  - → FETCH.
- FETCH:
  - `mem_addr_sel=0`.
  - → LATCH.
- LATCH:
  - `mem_addr_sel=0`; `ir` ← `mem_rdata` at the clock edge.
  - If C-instruction with `ir[12]=1`: → MREAD; otherwise → EXEC. The decision uses the incoming `mem_rdata`.
- MREAD:
  - `mem_addr_sel=1`.
  - → EXEC.
- EXEC, A-instruction:
  - `a_load=1`, `a_sel=0`, `pc_inc=1`.
- EXEC, C-instruction:
  - `alu_y_sel = ir[12]`; `mem_addr_sel=1`.
  - `a_load = ir[5]` with `a_sel=1`; `d_load = ir[4]`; `mem_we = ir[3]`.
  - jump = (`ir[2]`&ng) | (`ir[1]`&zr) | (`ir[0]`&!zr&!ng).
  - jump=1 → `pc_load=1`, `pc_target_sel=0`; jump=0 → `pc_inc=1`. The two are never both high.
- EXEC completion:
  - `retired` += 1 at the EXEC clock edge.
  - Next state is FETCH, or HALT on the halt condition.
- Halt condition (checked in EXEC):
  - The instruction is a C-instruction with `ir[2:0]=111`.
  - The previous retired instruction was an A-instruction; an internal flag is set when an A-instruction retires and cleared when a C-instruction retires.
  - `a_q == pc_q - 1`, computed modulo 2^ADDR_W.
  - On halt, the jump strobes are still issued that cycle.
- HALT:
  - All strobes 0; `start` ignored; left only by `reset`.
- Reset:
  - Takes priority over everything.
  - All strobes are combinationally gated by `!reset`, so no write occurs in the reset cycle.
  - Next state IDLE; `ir`=0, `retired`=0, halt flag cleared.
- Reset values: every output 0 in IDLE after reset (`busy=0`, `halted=0`).

## Timing
- Latency per instruction, from FETCH entry to next FETCH entry:
  - A-instruction: 3 cycles.
  - C-instruction with a=0: 3 cycles.
  - C-instruction with a=1: 4 cycles.
- Start: `start` seen in IDLE at edge k → BOOT in cycle k+1 → FETCH in cycle k+2.
- RAM read is synchronous, 1-cycle latency. `mem_rdata` sampled in LATCH/EXEC reflects the address driven one cycle earlier.
- M read-modify-write: in EXEC, `mem_addr_sel=1` is held; ALU sees the old M; the write occurs at the EXEC edge.
- Flags `alu_zr`/`alu_ng` are sampled combinationally in EXEC only.
- Strobes are Moore outputs of state/IR, gated by `reset`. No strobe is asserted outside the states listed.

## Test plan
- Reset then `start` pulse:
  - BOOT shows `pc_load=1`, `pc_target_sel=1`.
  - FETCH follows with `mem_addr_sel=0`.
  - `busy=1` from BOOT onward.
- A-instruction 0x0005:
  - LATCH→EXEC in 2 cycles after FETCH.
  - EXEC shows `a_load=1`, `a_sel=0`, `pc_inc=1`, `pc_load=0`.
  - `retired` 0→1.
- `D=M+1` (0xFDD0):
  - Path FETCH, LATCH, MREAD, EXEC.
  - MREAD shows `mem_addr_sel=1`.
  - EXEC shows `alu_y_sel=1`, `alu_ctrl=110111`, `d_load=1`, `mem_we=0`.
- `0;JEQ` (0xEA82):
  - With `alu_zr=1`: `pc_load=1`, `pc_target_sel=0`, `pc_inc=0`.
  - Rerun with `alu_zr=0`, `alu_ng=0`: `pc_inc=1`, `pc_load=0`.
- Halt idiom: `@70` at address 70, then `0;JMP` at address 71 with `a_q=70`, `pc_q=71`.
  - EXEC is followed by HALT: `halted=1`, `busy=0`.
  - No further FETCH; a later `start` is ignored.
- `M=D` (0xE308): assert `reset` in its EXEC cycle.
  - `mem_we=0` that cycle.
  - Next state IDLE; `retired` resets to 0; `ir`=0.
